uart_rx: RTL and testbench
==========================

# uart_rx

Receive-side UART: deserializes an asynchronous 8N1 serial line into parallel words and presents them on a valid/ready handshake. It pairs with the existing transmitter using the same parameter set and oversampling-by-counter scheme. It sits between the board-level RX pin and the link logic.

## Interface
- DATA_WIDTH, 8, data bits per frame, sent LSB first
- BAUD_RATE, 115_200, line rate in bit/s
- CLK_FREQ, 50_000_000, clk frequency in Hz
- Derived localparams: PULSE_WIDTH = CLK_FREQ/BAUD_RATE (434 at defaults), HALF_PULSE_WIDTH = PULSE_WIDTH/2 (217), LB_PULSE_WIDTH = $clog2(PULSE_WIDTH), LB_DATA_WIDTH = $clog2(DATA_WIDTH)

Ports:
- clk  input  1  system clock; all logic is on its rising edge
- reset  input  1  synchronous, active-high reset
- ena  input  1  receiver enable
- rxd  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_WIDTH  received word
- rx_valid  output  1  rx_data holds an unread word
- rx_ready  input  1  consumer accepts the word
- rx_busy  output  1  a frame is being received
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: word dropped because rx_valid was still high
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without the parity option)

## Operation
- rxd passes through a 2-flop synchronizer. Both flops reset to 1.
- States: IDLE, START, DATA, PARITY (parity option only), STOP, WAIT_HIGH.
- IDLE: a synchronized 1->0 transition loads the counter and moves to START.
- START: after HALF_PULSE_WIDTH cycles, sample the line.
  - Low: go to DATA with the bit index at 0.
  - High: false start; return to IDLE with no output.
- DATA: every PULSE_WIDTH cycles, sample into a shift register, LSB first. After DATA_WIDTH samples, go to PARITY or STOP.
- STOP: after PULSE_WIDTH cycles, sample the line.
  - High: commit the word and return to IDLE.
  - Low: pulse frame_err, discard the word, go to WAIT_HIGH.
- WAIT_HIGH: stay until the synchronized line is 1, then go to IDLE. This covers the break condition.
- Commit rules:
  - If rx_valid is 0, or rx_ready is 1 in the same cycle, load rx_data and set rx_valid.
  - Otherwise, keep the old word and pulse overrun.
- Handshake:
  - rx_valid stays high until a cycle with rx_ready=1, then clears next cycle unless a commit coincides, in which case it stays high with the new data.
  - rx_data is stable while rx_valid=1.
- ena=0 forces IDLE and clears the counter and bit index, aborting any frame silently. rx_data and rx_valid are unaffected; the handshake keeps working.
- rx_busy = (state != IDLE).
- Counter width is LB_PULSE_WIDTH; it never wraps, and reloads on every bit boundary.

## Timing
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, parity_err=0, state=IDLE.
- Reset mid-frame: abandon the frame immediately with no pulses.
- rxd edge to state leaving IDLE: 3 cycles (2 sync flops plus edge register).
- Stop-bit sample to rx_valid high: 1 cycle, registered.
- Error pulses are registered, exactly 1 cycle wide, and coincide with the cycle rx_valid would have risen.
- Back-to-back frames:
  - The receiver returns to IDLE at mid-stop-bit, so a start edge arriving half a bit later is caught.
  - Sustained full rate is supported.

## Configuration
- UART_RX_PARITY_EN defined:
  - One even-parity bit is expected after the data bits, sampled PULSE_WIDTH after the last data bit.
  - A mismatch pulses parity_err together with commit; the word is still committed.
  - A framing error takes precedence, and the word is discarded.
- Macro absent: no PARITY state, and parity_err is constant 0.

## Structure
- Package uart_pkg holds:
  - the rx_state_t enum
  - the default BAUD_RATE/CLK_FREQ constants shared with the transmitter
- Sub-module sync_2ff: a generic 2-flop synchronizer with a reset value parameter, instanced with reset value 1.
- All other logic is flat in uart_rx.

## Test plan
- Frame 0x55 at default parameters, rx_ready held 1 -> rx_valid pulses 1 cycle with rx_data=0x55, no error pulses.
- 100-cycle low glitch on an idle line -> false start, back to IDLE, rx_valid stays 0, rx_busy drops within 220 cycles.
- Frame 0xA3 with stop bit driven low -> frame_err 1-cycle pulse, rx_valid stays 0; the receiver ignores the line until it is high, then 0x3C is received correctly.
- Two frames 0x11, 0x22 back-to-back with rx_ready=0 -> rx_data stays 0x11, overrun pulses once; after rx_ready=1 for one cycle, rx_valid clears.
- reset asserted for 1 cycle during DATA bit 4 of a frame -> all outputs 0 next cycle; a following 0x7E frame is received correctly.
- With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> rx_data=0x07 with parity_err pulse; with parity bit 1 -> no pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default line parameters.
// Build option UART_RX_PARITY_EN adds the PARITY state for the even-parity receiver.
package uart_pkg;

  localparam int DEFAULT_BAUD_RATE = 115_200;
  localparam int DEFAULT_CLK_FREQ  = 50_000_000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
// No build options (UART_RX_PARITY_EN does not affect this file).
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with counter-based mid-bit sampling and a valid/ready output handshake.
// Define UART_RX_PARITY_EN to expect one even-parity bit after the data bits.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int LB_PULSE_WIDTH   = $clog2(PULSE_WIDTH);
  localparam int LB_DATA_WIDTH    = $clog2(DATA_WIDTH);

  // Counter runs down to zero, so reloads are one less than the interval length.
  localparam logic [LB_PULSE_WIDTH-1:0] FULL_RELOAD = LB_PULSE_WIDTH'(PULSE_WIDTH - 1);
  localparam logic [LB_PULSE_WIDTH-1:0] HALF_RELOAD = LB_PULSE_WIDTH'(HALF_PULSE_WIDTH - 1);
  localparam logic [LB_PULSE_WIDTH-1:0] COUNT_ONE   = LB_PULSE_WIDTH'(1);
  localparam logic [LB_DATA_WIDTH-1:0]  LAST_BIT    = LB_DATA_WIDTH'(DATA_WIDTH - 1);
  localparam logic [LB_DATA_WIDTH-1:0]  BIT_ONE     = LB_DATA_WIDTH'(1);

  logic                      w_rxdSync;
  logic                      w_startEdge;
  logic                      w_tick;
  logic                      r_rxdPrev;
  rx_state_t                 r_state;
  logic [LB_PULSE_WIDTH-1:0] r_count;
  logic [LB_DATA_WIDTH-1:0]  r_bitIdx;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [DATA_WIDTH-1:0]     r_rxData;
  logic                      r_rxValid;
  logic                      r_frameErr;
  logic                      r_overrun;
`ifdef UART_RX_PARITY_EN
  logic                      r_parityBad;
  logic                      r_parityErr;
`endif

  sync_2ff #(
    .RESET_VALUE (1'b1)
  ) u_rxdSync (
    .clk     (clk),
    .reset   (reset),
    .i_async (rxd),
    .o_sync  (w_rxdSync)
  );

  assign w_startEdge = r_rxdPrev & ~w_rxdSync;
  assign w_tick      = (r_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_bitIdx   <= '0;
      r_shift    <= '0;
      r_rxdPrev  <= 1'b1;
      r_rxData   <= '0;
      r_rxValid  <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityBad <= 1'b0;
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_rxdPrev  <= w_rxdSync;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parityErr <= 1'b0;
`endif
      // A read clears valid; a coinciding commit below overrides this.
      if (rx_ready) begin
        r_rxValid <= 1'b0;
      end

      if (!ena) begin
        r_state  <= IDLE;
        r_count  <= '0;
        r_bitIdx <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_startEdge) begin
              r_state <= START;
              r_count <= HALF_RELOAD;
            end
          end

          START: begin
            if (w_tick) begin
              if (w_rxdSync) begin
                r_state <= IDLE;
              end else begin
                r_state  <= DATA;
                r_bitIdx <= '0;
                r_count  <= FULL_RELOAD;
              end
            end else begin
              r_count <= r_count - COUNT_ONE;
            end
          end

          DATA: begin
            if (w_tick) begin
              r_shift <= {w_rxdSync, r_shift[DATA_WIDTH-1:1]};
              r_count <= FULL_RELOAD;
              if (r_bitIdx == LAST_BIT) begin
                r_bitIdx <= '0;
`ifdef UART_RX_PARITY_EN
                r_state  <= PARITY;
`else
                r_state  <= STOP;
`endif
              end else begin
                r_bitIdx <= r_bitIdx + BIT_ONE;
              end
            end else begin
              r_count <= r_count - COUNT_ONE;
            end
          end

`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (w_tick) begin
              r_parityBad <= ^{r_shift, w_rxdSync};
              r_count     <= FULL_RELOAD;
              r_state     <= STOP;
            end else begin
              r_count <= r_count - COUNT_ONE;
            end
          end
`endif

          // Leaving at mid-stop-bit leaves half a bit of slack for the next start edge.
          STOP: begin
            if (w_tick) begin
              if (w_rxdSync) begin
                r_state <= IDLE;
                if (!r_rxValid || rx_ready) begin
                  r_rxData  <= r_shift;
                  r_rxValid <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                r_parityErr <= r_parityBad;
`endif
              end else begin
                r_frameErr <= 1'b1;
                r_state    <= WAIT_HIGH;
              end
            end else begin
              r_count <= r_count - COUNT_ONE;
            end
          end

          WAIT_HIGH: begin
            if (w_rxdSync) begin
              r_state <= IDLE;
            end
          end

          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign rx_data   = r_rxData;
  assign rx_valid  = r_rxValid;
  assign rx_busy   = (r_state != IDLE);
  assign frame_err = r_frameErr;
  assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parityErr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames are driven bit by bit while a per-cycle line model predicts the handshake and pulses.
// Define UART_RX_PARITY_EN for both bench and RTL to cover the parity build.
module tb_uart_rx;

  localparam int DATA_WIDTH = 8;
  localparam int BAUD_RATE  = 115_200;
  localparam int CLK_FREQ   = 50_000_000;
  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT   = BIT_CYCLES / 2;
`ifdef UART_RX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  // Start edge reaches the FSM after 3 edges, the start bit is judged half a bit later, then one bit time per bit up to stop.
  localparam int STOP_SAMPLE_DELAY = 3 + HALF_BIT + BIT_CYCLES * (DATA_WIDTH + PARITY_BITS + 1);

  typedef struct {
    int             cycle;
    logic [7:0]     data;
    bit             stopOk;
    bit             parityBad;
  } frameEvent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  frameEvent_t expQ[$];
  int          edgeCount = 0;
  int          checkCount = 0;
  int          passCount = 0;

  logic        modelValid = 1'b0;
  logic [7:0]  modelData = 8'h00;
  int          validRises = 0;
  int          validHighCycles = 0;
  logic [7:0]  lastDataSeen = 8'h00;
  int          frameErrSeen = 0;
  int          overrunSeen = 0;
  int          parityErrSeen = 0;

  uart_rx #(
    .DATA_WIDTH (DATA_WIDTH),
    .BAUD_RATE  (BAUD_RATE),
    .CLK_FREQ   (CLK_FREQ)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ena        (ena),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting at the current edge; abortKind 1 = reset, 2 = ena low, during data bit abortBit.
  task automatic applyStimulus(input logic [7:0] data, input bit stopBit, input bit parityBit,
                               input int abortKind, input int abortBit);
    logic [11:0] bits;
    int          nBits;
    frameEvent_t ev;
    nBits = 1 + DATA_WIDTH + PARITY_BITS + 1;
    bits = '0;
    for (int i = 0; i < DATA_WIDTH; i++) bits[1 + i] = data[i];
    if (PARITY_BITS == 1) bits[1 + DATA_WIDTH] = parityBit;
    bits[nBits - 1] = stopBit;
    ev.cycle     = edgeCount + STOP_SAMPLE_DELAY;
    ev.data      = data;
    ev.stopOk    = stopBit;
    ev.parityBad = (PARITY_BITS == 1) && ((($countones(data) + int'(parityBit)) % 2) == 1);
    if (abortKind == 0) expQ.push_back(ev);
    for (int b = 0; b < nBits; b++) begin
      rxd = bits[b];
      if (abortKind != 0 && b == abortBit + 1) begin
        waitCycles(200);
        if (abortKind == 1) reset = 1'b1;
        else ena = 1'b0;
        rxd = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        ena = 1'b1;
        return;
      end
      waitCycles(BIT_CYCLES);
    end
  endtask

  // Line model: each edge applies the read, then any frame whose stop bit is judged at that edge.
  initial begin : compareProc
    bit          rdy;
    bit          rst;
    bit          oldValid;
    bit          expFe;
    bit          expOv;
    bit          expPe;
    logic        prevValid;
    frameEvent_t ev;
    prevValid = 1'b0;
    forever begin
      @(posedge clk);
      edgeCount++;
      rdy = rx_ready;
      rst = reset;
      @(negedge clk);
      expFe = 1'b0;
      expOv = 1'b0;
      expPe = 1'b0;
      if (rst) begin
        modelValid = 1'b0;
        modelData  = 8'h00;
      end else begin
        oldValid = modelValid;
        if (modelValid && rdy) modelValid = 1'b0;
        if (expQ.size() > 0 && expQ[0].cycle == edgeCount) begin
          ev = expQ.pop_front();
          if (!ev.stopOk) expFe = 1'b1;
          else begin
            expPe = ev.parityBad;
            if (!oldValid || rdy) begin
              modelValid = 1'b1;
              modelData  = ev.data;
            end else expOv = 1'b1;
          end
        end
      end
      checkOutput("rx_valid", rx_valid, modelValid);
      checkOutput("rx_data", rx_data, modelData);
      checkOutput("frame_err", frame_err, expFe);
      checkOutput("overrun", overrun, expOv);
      checkOutput("parity_err", parity_err, expPe);
      if (rx_valid === 1'b1) validHighCycles++;
      if (rx_valid === 1'b1 && prevValid !== 1'b1) begin
        validRises++;
        lastDataSeen = rx_data;
      end
      if (frame_err === 1'b1) frameErrSeen++;
      if (overrun === 1'b1) overrunSeen++;
      if (parity_err === 1'b1) parityErrSeen++;
      prevValid = rx_valid;
    end
  end

  initial begin : mainProc
    int rises0;
    int high0;
    int fe0;
    int ov0;
    int pe0;
    reset    = 1'b1;
    ena      = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    $display("[TB] reset released");
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_busy", rx_busy, 1'b0);
    waitCycles(50);

    $display("[TB] frame 0x55 with rx_ready held high");
    rx_ready = 1'b1;
    high0 = validHighCycles;
    applyStimulus(8'h55, 1'b1, 1'b0, 0, 0);
    waitCycles(20);
    checkOutput("t1_valid_cycles", validHighCycles - high0, 1);
    checkOutput("t1_data", lastDataSeen, 8'h55);
    checkOutput("t1_valid_low", rx_valid, 1'b0);
    checkOutput("t1_no_errors", frameErrSeen + overrunSeen + parityErrSeen, 0);

    $display("[TB] 100-cycle low glitch");
    rises0 = validRises;
    rxd = 1'b0;
    waitCycles(50);
    checkOutput("glitch_busy", rx_busy, 1'b1);
    waitCycles(50);
    rxd = 1'b1;
    waitCycles(125);
    checkOutput("glitch_idle", rx_busy, 1'b0);
    checkOutput("glitch_no_word", validRises - rises0, 0);

    $display("[TB] frame 0xA3 with low stop bit, then break, then 0x3C");
    fe0 = frameErrSeen;
    rises0 = validRises;
    applyStimulus(8'hA3, 1'b0, 1'b0 ^ (^8'hA3), 0, 0);
    waitCycles(1500);
    checkOutput("break_busy", rx_busy, 1'b1);
    rxd = 1'b1;
    waitCycles(300);
    checkOutput("ferr_pulses", frameErrSeen - fe0, 1);
    checkOutput("ferr_no_word", validRises - rises0, 0);
    applyStimulus(8'h3C, 1'b1, ^8'h3C, 0, 0);
    waitCycles(10);
    checkOutput("after_break_data", lastDataSeen, 8'h3C);

    $display("[TB] back-to-back 0x11, 0x22 with rx_ready low");
    rx_ready = 1'b0;
    ov0 = overrunSeen;
    waitCycles(5);
    applyStimulus(8'h11, 1'b1, ^8'h11, 0, 0);
    applyStimulus(8'h22, 1'b1, ^8'h22, 0, 0);
    waitCycles(10);
    checkOutput("ovr_data", rx_data, 8'h11);
    checkOutput("ovr_valid", rx_valid, 1'b1);
    checkOutput("ovr_pulses", overrunSeen - ov0, 1);
    rx_ready = 1'b1;
    waitCycles(1);
    rx_ready = 1'b0;
    checkOutput("ovr_read_clears", rx_valid, 1'b0);
    checkOutput("ovr_data_kept", rx_data, 8'h11);

    $display("[TB] reset during data bit 4");
    applyStimulus(8'h5A, 1'b1, ^8'h5A, 0, 0);
    waitCycles(10);
    checkOutput("pre_reset_valid", rx_valid, 1'b1);
    applyStimulus(8'h99, 1'b1, ^8'h99, 1, 4);
    checkOutput("rst_valid", rx_valid, 1'b0);
    checkOutput("rst_data", rx_data, 8'h00);
    checkOutput("rst_busy", rx_busy, 1'b0);
    checkOutput("rst_pulses", {frame_err, overrun, parity_err}, 3'b000);
    waitCycles(100);
    rx_ready = 1'b1;
    applyStimulus(8'h7E, 1'b1, ^8'h7E, 0, 0);
    waitCycles(10);
    checkOutput("post_reset_data", lastDataSeen, 8'h7E);

    $display("[TB] ena dropped mid-frame with a word pending");
    rx_ready = 1'b0;
    applyStimulus(8'hC4, 1'b1, ^8'hC4, 0, 0);
    waitCycles(10);
    applyStimulus(8'h33, 1'b1, ^8'h33, 2, 2);
    checkOutput("ena_busy", rx_busy, 1'b0);
    checkOutput("ena_valid_kept", rx_valid, 1'b1);
    checkOutput("ena_data_kept", rx_data, 8'hC4);
    waitCycles(100);
    rx_ready = 1'b1;
    waitCycles(2);
    checkOutput("ena_read_clears", rx_valid, 1'b0);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity: 0x07 with wrong then right parity bit");
    pe0 = parityErrSeen;
    applyStimulus(8'h07, 1'b1, 1'b0, 0, 0);
    waitCycles(10);
    checkOutput("par_bad_data", lastDataSeen, 8'h07);
    checkOutput("par_bad_pulse", parityErrSeen - pe0, 1);
    pe0 = parityErrSeen;
    applyStimulus(8'h07, 1'b1, 1'b1, 0, 0);
    waitCycles(10);
    checkOutput("par_ok_pulse", parityErrSeen - pe0, 0);
`else
    pe0 = parityErrSeen;
    checkOutput("no_parity_pulses", pe0, 0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
